// File: rtl/rs_debounce_ctrl.sv
// rs_debounce_ctrl: synchronise and debounce raw set/reset lines into a registered RS state with edge pulses.
// Optional conflict flag enabled by defining RS_CONFLICT_FLAG_EN.
module rs_debounce_ctrl #(
   parameter int DB_CYCLES = 4,
   parameter int CNT_W     = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic r_in,
   input  logic s_in,
`ifdef RS_CONFLICT_FLAG_EN
   input  logic clr_conflict,
   output logic conflict,
`endif
   output logic q,
   output logic q_b,
   output logic r_pulse,
   output logic s_pulse
);
   typedef enum logic [1:0] {ST_RST = 2'b00, ST_SET = 2'b01, ST_BOTH = 2'b10} state_e;
   // Channel bit 0 is reset, bit 1 is set.
   logic [1:0] sync1_q, sync2_q, db_q, db_d, db_prev_q, pulse_q;
   logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0] rs;
   state_e state_q, state_d;
   logic q_q, q_b_q;
   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = (sync2_q[i] == db_q[i] || cnt_q[i] == CNT_W'(DB_CYCLES - 1)) ? '0 : cnt_q[i] + CNT_W'(1);
         db_d[i]  = (sync2_q[i] != db_q[i] && cnt_q[i] == CNT_W'(DB_CYCLES - 1)) ? sync2_q[i] : db_q[i];
      end
   end
   assign rs = {db_q[0], db_q[1]};
   always_comb begin
      state_d = ST_RST;
      case (state_q)
         ST_RST:  state_d = rs == 2'b01 ? ST_SET : rs == 2'b11 ? ST_BOTH : ST_RST;
         ST_SET:  state_d = rs == 2'b10 ? ST_RST : rs == 2'b11 ? ST_BOTH : ST_SET;
         ST_BOTH: state_d = rs == 2'b01 ? ST_SET : rs == 2'b11 ? ST_BOTH : ST_RST;
         default: state_d = ST_RST;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         cnt_q     <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
         pulse_q   <= '0;
         state_q   <= ST_RST;
         q_q       <= 1'b0;
         q_b_q     <= 1'b1;
      end else begin
         sync1_q   <= {s_in, r_in};
         sync2_q   <= sync1_q;
         cnt_q     <= cnt_d;
         db_q      <= db_d;
         db_prev_q <= db_q;
         pulse_q   <= db_q & ~db_prev_q;
         state_q   <= state_d;
         q_q       <= state_d == ST_SET;
         q_b_q     <= state_d == ST_RST;
      end
   end
`ifdef RS_CONFLICT_FLAG_EN
   logic conflict_q;
   always_ff @(posedge clk) begin
      if (rst) conflict_q <= 1'b0;
      else conflict_q <= (state_d == ST_BOTH && state_q != ST_BOTH) ? 1'b1 : clr_conflict ? 1'b0 : conflict_q;
   end
   assign conflict = conflict_q;
`endif
   assign q       = q_q;
   assign q_b     = q_b_q;
   assign r_pulse = pulse_q[0];
   assign s_pulse = pulse_q[1];
endmodule

// File: tb/tb_rs_debounce_ctrl.sv
// tb_rs_debounce_ctrl: table-driven per-cycle checks of q/q_b/pulses, plus corner-case sequences.
module tb_rs_debounce_ctrl;
   logic clk = 1'b0, rst = 1'b1, r_in = 1'b0, s_in = 1'b0;
   logic q, q_b, r_pulse, s_pulse;
   int total = 0, bad = 0;
`ifdef RS_CONFLICT_FLAG_EN
   logic clr_conflict = 1'b0, conflict;
`endif
   rs_debounce_ctrl #(.DB_CYCLES(4), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .r_in(r_in), .s_in(s_in),
`ifdef RS_CONFLICT_FLAG_EN
      .clr_conflict(clr_conflict), .conflict(conflict),
`endif
      .q(q), .q_b(q_b), .r_pulse(r_pulse), .s_pulse(s_pulse)
   );
   always #5 clk = ~clk;
   typedef struct {
      logic rst, r, s;
      int n;
      logic [3:0] exp;
   } vec_t;
   vec_t tbl[$];
   task automatic add(input logic rs_, input logic r, input logic s, input int n, input logic [3:0] e);
      vec_t v;
      v.rst = rs_; v.r = r; v.s = s; v.n = n; v.exp = e;
      tbl.push_back(v);
   endtask
   // Drive inputs, then check {q,q_b,r_pulse,s_pulse} after each of n edges.
   task automatic run(input string name, input logic rs_, input logic r, input logic s, input int n, input logic [3:0] e);
      rst = rs_; r_in = r; s_in = s;
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         total++;
         if ({q, q_b, r_pulse, s_pulse} !== e) begin
            bad++;
            $display("FAIL %s cycle %0d: got {q,q_b,rp,sp}=%b expected %b", name, c, {q, q_b, r_pulse, s_pulse}, e);
         end
      end
   endtask
`ifdef RS_CONFLICT_FLAG_EN
   task automatic crun(input string name, input logic r, input logic s, input logic clr, input int n, input logic e);
      rst = 1'b0; r_in = r; s_in = s; clr_conflict = clr;
      for (int c = 0; c < n; c++) begin
         @(posedge clk); #1;
         total++;
         if (conflict !== e) begin
            bad++;
            $display("FAIL %s cycle %0d: got conflict=%b expected %b", name, c, conflict, e);
         end
      end
   endtask
`endif
   initial begin
      add(1, 1, 1, 2, 4'b0100);
      add(0, 1, 1, 6, 4'b0100);
      add(0, 1, 1, 1, 4'b0011);
      add(0, 1, 1, 1, 4'b0000);
      add(0, 0, 0, 6, 4'b0000);
      add(0, 0, 0, 1, 4'b0100);
      add(0, 0, 1, 6, 4'b0100);
      add(0, 0, 1, 1, 4'b1001);
      add(0, 0, 1, 1, 4'b1000);
      add(0, 0, 1, 3, 4'b1000);
      add(0, 0, 0, 8, 4'b1000);
      add(0, 1, 0, 6, 4'b1000);
      add(0, 1, 0, 1, 4'b0110);
      add(0, 1, 0, 1, 4'b0100);
      add(0, 0, 0, 8, 4'b0100);
      add(0, 0, 1, 1, 4'b0100);
      add(0, 0, 0, 1, 4'b0100);
      add(0, 0, 1, 1, 4'b0100);
      add(0, 0, 0, 1, 4'b0100);
      add(0, 0, 0, 8, 4'b0100);
      add(0, 0, 1, 3, 4'b0100);
      add(0, 0, 0, 8, 4'b0100);
      add(0, 0, 1, 4, 4'b0100);
      add(0, 0, 0, 2, 4'b0100);
      add(0, 0, 0, 1, 4'b1001);
      add(0, 0, 0, 1, 4'b1000);
      add(0, 0, 0, 8, 4'b1000);
      for (int i = 0; i < tbl.size(); i++)
         run($sformatf("vec%0d", i), tbl[i].rst, tbl[i].r, tbl[i].s, tbl[i].n, tbl[i].exp);
      run("simul_wait", 0, 1, 1, 6, 4'b1000);
      run("simul_both", 0, 1, 1, 1, 4'b0011);
      run("simul_hold", 0, 1, 1, 1, 4'b0000);
      run("release_wait", 0, 0, 0, 6, 4'b0000);
      run("release_rst", 0, 0, 0, 1, 4'b0100);
      run("release_hold", 0, 0, 0, 4, 4'b0100);
      run("midrst_pre", 0, 0, 1, 3, 4'b0100);
      run("midrst_rst", 1, 0, 1, 1, 4'b0100);
      run("midrst_wait", 0, 0, 1, 6, 4'b0100);
      run("midrst_set", 0, 0, 1, 1, 4'b1001);
      run("midrst_hold", 0, 0, 1, 1, 4'b1000);
`ifdef RS_CONFLICT_FLAG_EN
      crun("cf_wait", 1, 1, 0, 6, 1'b0);
      crun("cf_enter", 1, 1, 0, 1, 1'b1);
      crun("cf_sticky", 0, 0, 0, 7, 1'b1);
      crun("cf_clear", 0, 0, 1, 1, 1'b0);
      crun("cf_cleared", 0, 0, 0, 2, 1'b0);
      crun("cf_clr_wait", 1, 1, 1, 6, 1'b0);
      crun("cf_set_wins", 1, 1, 1, 1, 1'b1);
      crun("cf_after", 1, 1, 0, 3, 1'b1);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
